// File: rtl/synth_pkg.sv
// Shared constants and types for the tone controller: the C4..C5 note table,
// FSM state encoding and the target half-period helper.
package synth_pkg;

  localparam int NUM_NOTES = 8;
  localparam int NOTE_W    = 20;
  localparam int IDX_W     = 3;
  localparam int MIN_HALF  = 2;

  // Half-period counts at 100 MHz; element 0 is C4, element 7 is C5.
  localparam logic [NUM_NOTES-1:0][NOTE_W-1:0] NOTE_HALF = {
    20'd95557,  20'd101239, 20'd113636, 20'd127551,
    20'd143172, 20'd151685, 20'd170265, 20'd191110
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PLAY    = 2'd2,
    RELEASE = 2'd3
  } tone_state_e;

  // Octave shift halves the period; clamp so the square wave never degenerates.
  function automatic logic [31:0] half_for(input logic [IDX_W-1:0] idx,
                                           input logic [1:0]       oct,
                                           input int               shift);
    logic [31:0] h;
    h = (32'(NOTE_HALF[idx]) >> shift) >> oct;
    if (h < 32'(MIN_HALF)) begin
      h = 32'(MIN_HALF);
    end
    return h;
  endfunction

endpackage

// File: rtl/tone_half_counter.sv
// Programmable down-counter that flips the tone register each time it expires
// and reloads itself from load_val_i in the same cycle.
module tone_half_counter #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic             run_i,
  output logic             expire_o,
  output logic             tone_o
);

  logic [DIV_W-1:0] count_q, count_d;
  logic             tone_q, tone_d;

  assign expire_o = run_i && (count_q == '0);
  assign tone_o   = tone_q;

  always_comb begin
    count_d = count_q;
    tone_d  = tone_q;
    if (clear_i) begin
      count_d = '0;
      tone_d  = 1'b0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (expire_o) begin
      count_d = load_val_i;
      tone_d  = ~tone_q;
    end else if (run_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tone_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tone_q  <= tone_d;
    end
  end

endmodule

// File: rtl/synth_tone_ctrl.sv
// Tone controller: synchronizes key levels, picks the highest key, looks up its
// half-period and sequences the half counter so retunes land only on boundaries.
module synth_tone_ctrl
  import synth_pkg::*;
#(
  parameter int NUM_KEYS    = 8,
  parameter int DIV_W       = 20,
  parameter int TABLE_SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_req,
  input  logic [1:0]          octave,
  output logic                tone_out,
  output logic                active,
  output logic [2:0]          note_idx,
  output logic                retune_ack
);

  logic [NUM_KEYS-1:0] sync_q, ks_q;
  logic [IDX_W-1:0]    tgt_idx;
  logic [DIV_W-1:0]    tgt_half;
  logic                key_any, retarget;

  tone_state_e         state_q, state_d;
  logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
  logic [DIV_W-1:0]    cur_half_q, cur_half_d;
  logic                retune_q, retune_d;

  logic                cnt_clear, cnt_load, cnt_run, cnt_expire, tone;
  logic [DIV_W-1:0]    cnt_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      ks_q   <= '0;
    end else begin
      sync_q <= key_req;
      ks_q   <= sync_q;
    end
  end

  // Fixed priority: the highest pressed key wins.
  always_comb begin
    tgt_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (ks_q[i]) begin
        tgt_idx = IDX_W'(i);
      end
    end
  end

  assign tgt_half = DIV_W'(half_for(tgt_idx, octave, TABLE_SHIFT));
  assign key_any  = |ks_q;
  assign retarget = (tgt_idx != cur_idx_q) || (tgt_half != cur_half_q);

  // Counting stops in RELEASE once the tone is already low, so no new high
  // phase can start after the last key has gone.
  assign cnt_run = (state_q == PLAY) || ((state_q == RELEASE) && (key_any || tone));

  tone_half_counter #(
    .DIV_W(DIV_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cnt_clear),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .run_i     (cnt_run),
    .expire_o  (cnt_expire),
    .tone_o    (tone)
  );

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    cur_half_d = cur_half_q;
    retune_d   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = cur_half_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (key_any) begin
          state_d    = LOAD;
          cur_idx_d  = tgt_idx;
          cur_half_d = tgt_half;
        end
      end
      LOAD: begin
        cnt_load = 1'b1;
        state_d  = PLAY;
      end
      PLAY: begin
        // A new pitch is only adopted at the moment the current half expires.
        if (cnt_expire && key_any && retarget) begin
          cnt_val    = tgt_half - 1'b1;
          cur_idx_d  = tgt_idx;
          cur_half_d = tgt_half;
          retune_d   = 1'b1;
        end
        if (!key_any) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (key_any) begin
          state_d = PLAY;
        end else if (!tone || cnt_expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_idx_q  <= '0;
      cur_half_q <= DIV_W'(MIN_HALF);
      retune_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      cur_half_q <= cur_half_d;
      retune_q   <= retune_d;
    end
  end

  assign tone_out   = tone;
  assign active     = (state_q != IDLE);
  assign note_idx   = cur_idx_q;
  assign retune_ack = retune_q;

endmodule

// File: tb/tb_synth_tone_ctrl.sv
// Self-checking bench for synth_tone_ctrl: directed pitch/retune/release cases
// plus random key and octave traffic against a cycle-level behavioural model.
module tb_synth_tone_ctrl;

  localparam int NUM_KEYS    = 8;
  localparam int DIV_W       = 20;
  localparam int TABLE_SHIFT = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_KEYS-1:0] key_req;
  logic [1:0]          octave;
  logic                tone_out, active, retune_ack;
  logic [2:0]          note_idx;

  int testsRun    = 0;
  int testsFailed = 0;
  int ackCount    = 0;
  int n;

  always #5 clk = ~clk;

  synth_tone_ctrl #(
    .NUM_KEYS   (NUM_KEYS),
    .DIV_W      (DIV_W),
    .TABLE_SHIFT(TABLE_SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_req   (key_req),
    .octave    (octave),
    .tone_out  (tone_out),
    .active    (active),
    .note_idx  (note_idx),
    .retune_ack(retune_ack)
  );

  int noteHalf [8] = '{191110, 170265, 151685, 143172, 127551, 113636, 101239, 95557};

  function automatic int topKey(input logic [7:0] k);
    int w = -1;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) w = i;
    end
    return w;
  endfunction

  function automatic int halfOf(input int idx, input int oct);
    int h;
    h = noteHalf[idx] / (1 << TABLE_SHIFT) / (1 << oct);
    return (h < 2) ? 2 : h;
  endfunction

  // Model: mode 0 silent, 1 starting, 2 sounding, 3 releasing; mRem counts
  // the cycles still to go in the current half, toggling when it reaches one.
  logic [7:0] d1, d2;
  int         mMode, mRem, mHalf, mIdx;
  logic       mTone, mAck;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 = '0; d2 = '0;
      mMode = 0; mRem = 0; mHalf = 2; mIdx = 0;
      mTone = 1'b0; mAck = 1'b0;
    end else begin
      logic [7:0] ks;
      int w, h;
      ks = d2; d2 = d1; d1 = key_req;
      w = topKey(ks);
      h = (w >= 0) ? halfOf(w, int'(octave)) : 0;
      mAck = 1'b0;
      case (mMode)
        0: begin
          mTone = 1'b0;
          if (w >= 0) begin mMode = 1; mIdx = w; mHalf = h; end
        end
        1: begin mRem = mHalf; mMode = 2; end
        2: begin
          if (mRem == 1) begin
            mTone = ~mTone;
            if (w >= 0 && (w != mIdx || h != mHalf)) begin
              mIdx = w; mHalf = h; mAck = 1'b1;
            end
            mRem = mHalf;
          end else mRem--;
          if (w < 0) mMode = 3;
        end
        default: begin
          if (w >= 0 || mTone) begin
            if (mRem == 1) begin
              mTone = ~mTone;
              mRem  = mHalf;
              if (w < 0) mMode = 0;
            end else mRem--;
            if (w >= 0) mMode = 2;
          end else mMode = 0;
        end
      endcase
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("mdlTone",   int'(tone_out),   int'(mTone));
      checkOutput("mdlActive", int'(active),     (mMode != 0) ? 1 : 0);
      checkOutput("mdlIdx",    int'(note_idx),   mIdx);
      checkOutput("mdlAck",    int'(retune_ack), int'(mAck));
      if (retune_ack) ackCount++;
    end
  end

  task automatic applyStimulus(input logic [7:0] k, input logic [1:0] o);
    key_req = k;
    octave  = o;
  endtask

  task automatic waitLevel(input logic lvl, input int maxCyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxCyc; i++) begin
      @(posedge clk); #1;
      if (tone_out == lvl) begin cyc = i; break; end
    end
  endtask

  task automatic waitAck(input int maxCyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxCyc; i++) begin
      @(posedge clk); #1;
      if (retune_ack) begin cyc = i; break; end
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(8'h00, 2'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut();
    checkOutput("rstTone",   int'(tone_out),   0);
    checkOutput("rstActive", int'(active),     0);
    checkOutput("rstIdx",    int'(note_idx),   0);
    checkOutput("rstAck",    int'(retune_ack), 0);

    // A4 from idle: latency and duty
    applyStimulus(8'h20, 2'd0);
    waitLevel(1'b1, 400, n);
    checkOutput("a4Rise", n - 1, 113);
    checkOutput("a4Idx", int'(note_idx), 5);
    waitLevel(1'b0, 400, n);
    checkOutput("a4High", n, 110);
    waitLevel(1'b1, 400, n);
    checkOutput("a4Low", n, 110);

    // Asynchronous reset in the middle of a high phase
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstTone",   int'(tone_out), 0);
    checkOutput("midRstActive", int'(active),   0);
    checkOutput("midRstIdx",    int'(note_idx), 0);
    applyStimulus(8'h00, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("idleAfterRst", int'(active), 0);

    // C5 + C4 held, then C5 dropped: retune to C4 at the boundary
    applyStimulus(8'h81, 2'd0);
    waitLevel(1'b1, 400, n);
    checkOutput("c5Idx", int'(note_idx), 7);
    waitLevel(1'b0, 400, n);
    checkOutput("c5High", n, 93);
    applyStimulus(8'h01, 2'd0);
    ackCount = 0;
    waitAck(300, n);
    checkOutput("retuneAt", n, 93);
    checkOutput("c4Idx", int'(note_idx), 0);
    waitLevel(1'b0, 400, n);
    checkOutput("c4High", n, 186);
    checkOutput("ackOnce", ackCount, 1);
    applyStimulus(8'h00, 2'd0);
    repeat (5) @(posedge clk);
    #1 checkOutput("c4Off", int'(active), 0);

    // Octave change mid-half takes effect only at the next boundary
    applyStimulus(8'h20, 2'd0);
    waitLevel(1'b1, 400, n);
    repeat (30) @(posedge clk);
    #1 octave = 2'd1;
    ackCount = 0;
    waitLevel(1'b0, 400, n);
    checkOutput("octKeep", 30 + n, 110);
    waitLevel(1'b1, 400, n);
    checkOutput("octNew", n, 55);
    waitLevel(1'b0, 400, n);
    checkOutput("octNew2", n, 55);
    checkOutput("octAck", ackCount, 1);
    applyStimulus(8'h00, 2'd0);
    repeat (5) @(posedge clk);

    // Release 40 cycles into a high phase: full high phase, then idle
    applyStimulus(8'h20, 2'd0);
    waitLevel(1'b1, 400, n);
    repeat (40) @(posedge clk);
    #1 key_req = 8'h00;
    waitLevel(1'b0, 400, n);
    checkOutput("relFall", n, 70);
    checkOutput("relIdle", int'(active), 0);

    // Re-press while releasing keeps the phase
    applyStimulus(8'h20, 2'd0);
    waitLevel(1'b1, 400, n);
    repeat (20) @(posedge clk);
    #1 key_req = 8'h00;
    repeat (20) @(posedge clk);
    #1 key_req = 8'h20;
    waitLevel(1'b0, 400, n);
    checkOutput("repressPhase", 40 + n, 110);
    checkOutput("repressActive", int'(active), 1);
    waitLevel(1'b1, 400, n);
    checkOutput("repressLow", n, 110);
    applyStimulus(8'h00, 2'd0);
    waitLevel(1'b0, 400, n);
    repeat (3) @(posedge clk);

    // One-cycle glitch on a key
    applyStimulus(8'h04, 2'd0);
    @(posedge clk);
    #1 key_req = 8'h00;
    repeat (10) @(posedge clk);
    #1 checkOutput("glitchIdle", int'(active), 0);

    // Random key/octave traffic, checked every cycle against the model
    for (int it = 0; it < 60; it++) begin
      logic [7:0] k;
      int hold;
      k    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      hold = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(1, 300));
      applyStimulus(k, 2'($urandom_range(0, 3)));
      repeat (hold) @(posedge clk);
      #1;
    end

    applyStimulus(8'h00, 2'd0);
    repeat (400) @(posedge clk);
    #1 checkOutput("finalIdle", int'(active), 0);
    checkOutput("finalTone", int'(tone_out), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
